// File: rtl/cnt_uart_pkg.sv
// Shared types and constants for the count-to-UART reporter.
// State enums, ASCII constants and the hex-digit encoder.
package cnt_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIGIT,
    NEWLINE
  } seq_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_t;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_HEX_OFS = 8'h37;
  localparam logic [7:0] ASCII_LF      = 8'h0A;

  function automatic logic [7:0] hex_ascii(
    input logic [3:0] v
  );
    if (v < 4'd10)
      return ASCII_ZERO + {4'd0, v};
    else
      return ASCII_HEX_OFS + {4'd0, v};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first, CLKS_PER_BIT cycles per bit.
// A start request is honoured in any state so frames can run back to back.
module uart_tx_byte
  import cnt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  ser_state_t   r_state;
  logic [W-1:0] r_baud;
  logic [2:0]   r_bit;
  logic [7:0]   r_shift;
  logic         r_tx;
  logic         w_tick;

  assign w_tick = (r_baud == LAST);
  assign done   = (r_state == S_STOP) && w_tick;
  assign tx     = r_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else if (start) begin
      r_state <= S_START;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= data;
      r_tx    <= 1'b0;
    end else begin
      if (r_state != S_IDLE)
        r_baud <= w_tick ? '0 : r_baud + 1'b1;
      unique case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
        end
        S_START: begin
          if (w_tick) begin
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end
        end
        S_STOP: begin
          if (w_tick)
            r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/cnt_uart_tx.sv
// Reports each new accumulator count as an ASCII hex digit over UART.
// A one-deep pending slot collapses changes that arrive mid-report.
module cnt_uart_tx
  import cnt_uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter int unsigned SEND_NEWLINE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cnt,
  output logic       tx,
  output logic       busy,
  output logic       overrun
);

  logic [3:0] r_cnt_q;
  logic [3:0] r_slot;
  logic       r_slot_vld;
  logic       r_overrun;
  seq_state_t r_state;

  seq_state_t w_state_nxt;
  logic       w_change;
  logic       w_consume;
  logic       w_start;
  logic [7:0] w_data;
  logic       w_done;
  logic       w_tx;

  assign w_change  = (cnt != r_cnt_q);
  assign w_consume = (r_state == IDLE) && r_slot_vld;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_data      = ASCII_LF;
    unique case (r_state)
      IDLE: begin
        if (r_slot_vld) begin
          w_start     = 1'b1;
          w_data      = hex_ascii(r_slot);
          w_state_nxt = DIGIT;
        end
      end
      DIGIT: begin
        if (w_done) begin
          if (SEND_NEWLINE != 0) begin
            w_start     = 1'b1;
            w_data      = ASCII_LF;
            w_state_nxt = NEWLINE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      NEWLINE: begin
        if (w_done)
          w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_q    <= '0;
      r_slot     <= '0;
      r_slot_vld <= 1'b0;
      r_overrun  <= 1'b0;
      r_state    <= IDLE;
    end else begin
      r_cnt_q <= cnt;
      r_state <= w_state_nxt;
      // A load in the same cycle as a consume replaces, not overruns.
      if (w_change) begin
        r_slot     <= cnt;
        r_slot_vld <= 1'b1;
        if (r_slot_vld && !w_consume)
          r_overrun <= 1'b1;
      end else if (w_consume) begin
        r_slot_vld <= 1'b0;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk  (clk),
    .rst  (rst),
    .start(w_start),
    .data (w_data),
    .tx   (w_tx),
    .done (w_done)
  );

  assign tx      = w_tx;
  assign busy    = (r_state != IDLE);
  assign overrun = r_overrun;

endmodule

// File: tb/tb_cnt_uart_tx.sv
// Bench for cnt_uart_tx: report-level model plus a UART line decoder.
// Directed steps from the test plan followed by random count changes.
module tb_cnt_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int REP   = 20 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cnt = 4'd0;
  logic       tx;
  logic       busy;
  logic       overrun;

  cnt_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .SEND_NEWLINE(1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cnt    (cnt),
    .tx     (tx),
    .busy   (busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Report-level model: a report occupies REP cycles once started.
  logic [7:0] expq[$];
  logic [7:0] rxq[$];
  string      hexs = "0123456789ABCDEF";
  logic [3:0] m_prev = 4'd0;
  logic [3:0] m_pval = 4'd0;
  bit         m_pv   = 1'b0;
  bit         m_ovr  = 1'b0;
  int         m_rem  = 0;
  int         m_rstcnt = 0;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin : model
    bit chg;
    bit cons;
    if (rst) begin
      if (m_rem > 0)
        void'(expq.pop_back());
      m_prev = 4'd0;
      m_pv   = 1'b0;
      m_ovr  = 1'b0;
      m_rem  = 0;
      m_rstcnt++;
    end else begin
      chg  = (cnt != m_prev);
      cons = (m_rem == 0) && m_pv;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == FRAME)
          expq.push_back(8'h0A);
      end
      if (cons) begin
        expq.push_back(hexs[m_pval]);
        m_rem = REP;
      end
      if (chg) begin
        if (m_pv && !cons)
          m_ovr = 1'b1;
        m_pv   = 1'b1;
        m_pval = cnt;
      end else if (cons) begin
        m_pv = 1'b0;
      end
      m_prev = cnt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_rem > 0);
      chk("overrun", overrun, m_ovr);
      if (m_rem == 0)
        chk("tx_idle", tx, 1);
    end
  end

  // Line decoder: samples mid-bit, drops frames cut by a reset.
  always begin : mon
    logic [7:0] b;
    logic       st;
    logic       sp;
    int         r0;
    @(negedge clk);
    if (chk_en && tx === 1'b0) begin
      r0 = m_rstcnt;
      b  = 8'h00;
      repeat (CPB / 2) @(negedge clk);
      st = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      sp = tx;
      if (m_rstcnt == r0) begin
        chk("start_bit", st, 0);
        chk("stop_bit", sp, 1);
        rxq.push_back(b);
      end
    end
  end

  task automatic step(input logic [3:0] c);
    @(posedge clk);
    #1;
    cnt = c;
  endtask

  task automatic dir_q(input string tag, input logic [7:0] e[$]);
    chk({tag, "_len"}, rxq.size(), e.size());
    for (int i = 0; i < e.size() && i < rxq.size(); i++)
      chk(tag, rxq[i], e[i]);
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_mlen"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < rxq.size(); i++)
      chk({tag, "_m"}, rxq[i], expq[i]);
    rxq.delete();
    expq.delete();
  endtask

  initial begin
    logic [7:0] eq[$];
    int         nb;
    int         guard;

    rst = 1'b1;
    cnt = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    repeat (200) @(posedge clk);
    chk("quiet_rx", rxq.size(), 0);

    step(4'd5);
    @(negedge clk);
    chk("n0_tx", tx, 1);
    @(negedge clk);
    chk("n1_tx", tx, 1);
    chk("n1_busy", busy, 0);
    @(negedge clk);
    chk("n2_tx", tx, 0);
    chk("n2_busy", busy, 1);
    nb    = 1;
    guard = 0;
    while (busy === 1'b1 && guard < 500) begin
      @(negedge clk);
      guard++;
      if (busy === 1'b1)
        nb++;
    end
    chk("busy_len", nb, REP);
    repeat (5) @(posedge clk);
    eq = {8'h35, 8'h0A};
    dir_q("rep5", eq);
    cmp_q("rep5");

    step(4'hB);
    repeat (100) @(posedge clk);
    eq = {8'h42, 8'h0A};
    dir_q("repB", eq);
    cmp_q("repB");

    step(4'd1);
    repeat (10) @(posedge clk);
    #1;
    cnt = 4'd2;
    repeat (5) @(posedge clk);
    #1;
    cnt = 4'd3;
    @(negedge clk);
    @(negedge clk);
    chk("ovr_set", overrun, 1);
    repeat (250) @(posedge clk);
    eq = {8'h31, 8'h0A, 8'h33, 8'h0A};
    dir_q("collapse", eq);
    cmp_q("collapse");

    step(4'd7);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    cnt = 4'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovr", overrun, 0);
    repeat (150) @(posedge clk);
    chk("mid_rst_rx", rxq.size(), 0);
    cmp_q("mid_rst");

    step(4'hE);
    repeat (100) @(posedge clk);
    step(4'hF);
    repeat (100) @(posedge clk);
    step(4'h0);
    repeat (100) @(posedge clk);
    chk("wrap_ovr", overrun, 0);
    eq = {8'h45, 8'h0A, 8'h46, 8'h0A, 8'h30, 8'h0A};
    dir_q("wrap", eq);
    cmp_q("wrap");

    for (int k = 0; k < 40; k++) begin
      step(4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 120)) @(posedge clk);
    end
    repeat (300) @(posedge clk);
    cmp_q("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
